regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin EXU/LSU arbitration,
// one-cycle write stage, and a busy scoreboard. Optional REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_rd,
    input  logic [63:0] exu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1Addr,
    input  logic [4:0]  rs2Addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic        rs1_fwd,
    output logic        rs2_fwd
`endif
);

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    grant_e      last_q, last_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [31:0] busy_q, busy_d;

    logic        acc;
    logic [4:0]  sel_rd;
    logic [63:0] sel_data;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    // Arbitration: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        last_d    = last_q;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                exu_ready = (last_q == GNT_LSU);
                lsu_ready = (last_q == GNT_EXU);
            end else begin
                exu_ready = exu_valid;
                lsu_ready = lsu_valid;
            end
        end
        if (exu_ready) begin
            last_d = GNT_EXU;
        end else if (lsu_ready) begin
            last_d = GNT_LSU;
        end
    end

    // Write stage next state: x0 writes complete the handshake but never write.
    always_comb begin
        acc       = exu_ready | lsu_ready;
        sel_rd    = lsu_ready ? lsu_rd : exu_rd;
        sel_data  = lsu_ready ? lsu_data : exu_data;
        wb_en_d   = acc && (sel_rd != 5'd0);
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (wb_en_d) begin
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
        end
    end

    // Scoreboard next state: issue sets, retirement clears, set beats clear.
    always_comb begin
        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            set_vec = 32'd1 << issue_rd;
        end
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_en_d) begin
            clr_vec = 32'd1 << sel_rd;
        end
`else
        if (wb_en_q) begin
            clr_vec = 32'd1 << wb_rd_q;
        end
`endif
        busy_d = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
    end

    // State registers; reset discards any in-flight write and all pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= GNT_LSU;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 64'd0;
            busy_q    <= 32'd0;
        end else begin
            last_q    <= last_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    // Hazard lookups and write-port outputs.
    always_comb begin
        rs1_busy = busy_q[rs1Addr] && (rs1Addr != 5'd0);
        rs2_busy = busy_q[rs2Addr] && (rs2Addr != 5'd0);
        wb_en    = wb_en_q;
        wb_rd    = wb_rd_q;
        wb_data  = wb_data_q;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the value being written this cycle to a matching source.
    always_comb begin
        rs1_fwd = wb_en_q && (wb_rd_q == rs1Addr) && (rs1Addr != 5'd0);
        rs2_fwd = wb_en_q && (wb_rd_q == rs2Addr) && (rs2Addr != 5'd0);
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1Addr, rs2Addr;
    logic        rs1_busy, rs2_busy;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
`ifdef REGFILE_WB_BYPASS_EN
    logic        rs1_fwd, rs2_fwd;
`endif

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef REGFILE_WB_BYPASS_EN
        , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: who was served last, which registers have a
    // pending write, and what the write port should show.
    bit          m_last_lsu;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [4:0]    m_wrd;
    bit [63:0]   m_wdata;

    task automatic model_reset();
        m_last_lsu = 1'b1;
        m_busy     = '0;
        m_wen      = 1'b0;
        m_wrd      = '0;
        m_wdata    = '0;
    endtask

    task automatic idle_inputs();
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
        rs1Addr = 0; rs2Addr = 0;
    endtask

    // One clock: check current outputs against the model, predict the
    // effect of the driven inputs, advance to just after the next edge.
    // win: 0 none, 1 EXU, 2 LSU.
    task automatic cycle(output int win);
        logic [4:0]  rd;
        logic [63:0] data;
        bit [31:0]   nb;
        #1;
        if (exu_valid && lsu_valid) win = m_last_lsu ? 1 : 2;
        else if (exu_valid) win = 1;
        else if (lsu_valid) win = 2;
        else win = 0;
        check("exu_ready", exu_ready, win == 1);
        check("lsu_ready", lsu_ready, win == 2);
        check("rs1_busy", rs1_busy, rs1Addr != 0 && m_busy[rs1Addr]);
        check("rs2_busy", rs2_busy, rs2Addr != 0 && m_busy[rs2Addr]);
        check("wb_en", wb_en, m_wen);
        check("wb_rd", wb_rd, m_wrd);
        check("wb_data", wb_data, m_wdata);
`ifdef REGFILE_WB_BYPASS_EN
        check("rs1_fwd", rs1_fwd, m_wen && m_wrd == rs1Addr && rs1Addr != 0);
        check("rs2_fwd", rs2_fwd, m_wen && m_wrd == rs2Addr && rs2Addr != 0);
`endif
        rd   = (win == 2) ? lsu_rd : exu_rd;
        data = (win == 2) ? lsu_data : exu_data;
        nb = m_busy;
`ifdef REGFILE_WB_BYPASS_EN
        if (win != 0 && rd != 0) nb[rd] = 1'b0;
`else
        if (m_wen) nb[m_wrd] = 1'b0;
`endif
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        if (win != 0) m_last_lsu = (win == 2);
        if (win != 0 && rd != 0) begin
            m_wen = 1; m_wrd = rd; m_wdata = data;
        end else begin
            m_wen = 0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        exu_valid = 1; lsu_valid = 1;
        rst = 1;
        model_reset();
        @(posedge clk); #2;
        check("rst_exu_ready", exu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        idle_inputs();
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
    endtask

    int w;
    int seq[4];

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        do_reset();

        // EXU-only write to x5.
        exu_valid = 1; exu_rd = 5; exu_data = 64'h1234;
        cycle(w);
        check("d19_grant", w, 1);
        idle_inputs();
        #1;
        check("d19_wb_en", wb_en, 1);
        check("d19_wb_rd", wb_rd, 5);
        check("d19_wb_data", wb_data, 64'h1234);
        cycle(w);
        cycle(w);

        // Tie for four cycles after reset: EXU first, then alternate.
        do_reset();
        exu_valid = 1; exu_rd = 3; exu_data = 64'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h44;
        for (int i = 0; i < 4; i++) begin
            cycle(w);
            seq[i] = w;
        end
        idle_inputs();
        check("d20_g0", seq[0], 1);
        check("d20_g1", seq[1], 2);
        check("d20_g2", seq[2], 1);
        check("d20_g3", seq[3], 2);
        cycle(w);

        // Hazard on x7 until its write retires; x0 never busy.
        issue_valid = 1; issue_rd = 7;
        cycle(w);
        idle_inputs();
        rs1Addr = 7;
        cycle(w);
        check("d21_busy_held", m_busy[7], 1);
        exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
        cycle(w);
        exu_valid = 0;
        cycle(w);
        cycle(w);

        // LSU write to x0: accepted, nothing written.
        issue_valid = 1; issue_rd = 2;
        cycle(w);
        idle_inputs();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFFFF;
        rs1Addr = 2;
        cycle(w);
        check("d22_grant", w, 2);
        idle_inputs();
        rs1Addr = 2;
        cycle(w);
        check("d22_x2_still_busy", m_busy[2], 1);

        // Re-issue x9 on the edge that retires x9.
        issue_valid = 1; issue_rd = 9;
        cycle(w);
        idle_inputs();
        exu_valid = 1; exu_rd = 9; exu_data = 64'h99;
        cycle(w);
        idle_inputs();
        issue_valid = 1; issue_rd = 9;
        rs1Addr = 9;
        cycle(w);
        idle_inputs();
        rs1Addr = 9;
        cycle(w);
        check("d23_busy9_kept", m_busy[9], 1);

        // Reset during the wb_en cycle for x12.
        issue_valid = 1; issue_rd = 12;
        cycle(w);
        idle_inputs();
        exu_valid = 1; exu_rd = 12; exu_data = 64'hC;
        cycle(w);
        idle_inputs();
        #1;
        check("d24_pre_wb_en", wb_en, 1);
        rst = 1;
        rs1Addr = 12;
        #1;
        check("d24_wb_en_drop", wb_en, 0);
        check("d24_busy_lost", rs1_busy, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        exu_valid = 1; exu_rd = 1; exu_data = 64'h1;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h2;
        cycle(w);
        check("d24_first_tie", w, 1);
        idle_inputs();
        cycle(w);

        // Random traffic; requests stay stable until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!exu_valid && $urandom_range(0, 1) == 1) begin
                exu_valid = 1;
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = {$urandom, $urandom};
            end
            if (!lsu_valid && $urandom_range(0, 1) == 1) begin
                lsu_valid = 1;
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = {$urandom, $urandom};
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1Addr     = 5'($urandom_range(0, 7));
            rs2Addr     = 5'($urandom_range(0, 7));
            cycle(w);
            if (w == 1) exu_valid = 0;
            if (w == 2) lsu_valid = 0;
        end
        idle_inputs();
        cycle(w);
        cycle(w);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
